// File: rtl/program_loader.sv
// Boot loader: length-prefixed 18-bit word stream -> instruction memory; CPU held in reset until a good image lands.
// Write issues the cycle after B2 and never stalls the link. LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module program_loader #(
  parameter int MAX_WORDS = 1022
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  output logic        o_in_ready,
  output logic        o_imem_we,
  output logic [9:0]  o_imem_addr,
  output logic [17:0] o_imem_wdata,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_error
);

  localparam logic [9:0] MAX_W = MAX_WORDS[9:0];

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR_HI, S_HDR_LO, S_W0, S_W1, S_W2, S_CHK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_HDR_HI, S_HDR_LO, S_W0, S_W1, S_W2, S_DONE, S_ERR} state_t;
`endif

  state_t      r_state;
  logic [9:0]  r_count;
  logic [9:0]  r_idx;
  logic [1:0]  r_b0;
  logic [7:0]  r_b1;
  logic        r_in_ready;
  logic        r_imem_we;
  logic [9:0]  r_imem_addr;
  logic [17:0] r_imem_wdata;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  logic        w_fire;
  logic        w_last;
  logic        w_count_bad;
  logic [9:0]  w_count;

  assign w_fire      = i_in_valid & r_in_ready;
  assign w_count     = {r_count[9:8], i_in_data};
  assign w_count_bad = (w_count == 10'd0) || (w_count > MAX_W);
  assign w_last      = (r_idx == r_count - 10'd1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_HDR_HI;
      r_count      <= 10'd0;
      r_idx        <= 10'd0;
      r_b0         <= 2'd0;
      r_b1         <= 8'd0;
      r_in_ready   <= 1'b1;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= 10'd0;
      r_imem_wdata <= 18'd0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor        <= 8'd0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        S_HDR_HI: if (w_fire) begin
          if (|i_in_data[7:2]) begin
            r_state <= S_ERR; r_error <= 1'b1; r_in_ready <= 1'b0;
          end else begin
            r_count[9:8] <= i_in_data[1:0];
            r_state      <= S_HDR_LO;
          end
        end
        S_HDR_LO: if (w_fire) begin
          if (w_count_bad) begin
            r_state <= S_ERR; r_error <= 1'b1; r_in_ready <= 1'b0;
          end else begin
            r_count <= w_count;
            r_state <= S_W0;
          end
        end
        S_W0: if (w_fire) begin
          if (|i_in_data[7:2]) begin
            r_state <= S_ERR; r_error <= 1'b1; r_in_ready <= 1'b0;
          end else begin
            r_b0    <= i_in_data[1:0];
            r_state <= S_W1;
          end
        end
        S_W1: if (w_fire) begin
          r_b1    <= i_in_data;
          r_state <= S_W2;
        end
        // Last word: the write still issues next cycle while the FSM moves on.
        S_W2: if (w_fire) begin
          r_imem_we    <= 1'b1;
          r_imem_addr  <= r_idx;
          r_imem_wdata <= {r_b0, r_b1, i_in_data};
          r_idx        <= r_idx + 10'd1;
          if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
            r_state <= S_CHK;
`else
            r_state    <= S_DONE;
            r_in_ready <= 1'b0;
`endif
          end else begin
            r_state <= S_W0;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: if (w_fire) begin
          r_in_ready <= 1'b0;
          if (i_in_data == r_xor) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_done     <= 1'b1;
          r_cpu_hold <= 1'b0;
          r_in_ready <= 1'b0;
        end
        S_ERR: r_in_ready <= 1'b0;
        default: begin
          r_state <= S_ERR; r_error <= 1'b1; r_in_ready <= 1'b0;
        end
      endcase
`ifdef LOADER_CHECKSUM_EN
      if (w_fire && r_state != S_CHK) r_xor <= r_xor ^ i_in_data;
`endif
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus randomized streams against a stream-parsing reference model.
module tb_program_loader;
  localparam int MAX_WORDS = 1022;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, imem_we, cpu_hold, done, error;
  logic [9:0]  imem_addr;
  logic [17:0] imem_wdata;

  always #5 clk = ~clk;

  program_loader #(.MAX_WORDS(MAX_WORDS)) dut (
    .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_imem_we(imem_we), .o_imem_addr(imem_addr),
    .o_imem_wdata(imem_wdata), .o_cpu_hold(cpu_hold), .o_done(done), .o_error(error)
  );

  typedef logic [7:0]  bq_t[$];
  typedef logic [17:0] dq_t[$];
  typedef logic [27:0] wq_t[$];   // {addr, data}

  wq_t wr_log;
  int  n_pass = 0;
  int  n_total = 0;

  always @(negedge clk) if (imem_we === 1'b1) wr_log.push_back({imem_addr, imem_wdata});

  // Reference: parse the byte stream by the format rules and predict writes and outcome.
  function automatic void model(input bq_t b, output wq_t w, output bit ok, output bit err, output int acc);
    int cnt, p;
    logic [7:0] x;
    w = {}; ok = 0; err = 0; acc = b.size();
    if (b.size() < 1) return;
    if (b[0][7:2] != 6'd0) begin err = 1; acc = 1; return; end
    if (b.size() < 2) return;
    cnt = int'(b[0][1:0]) * 256 + int'(b[1]);
    if (cnt == 0 || cnt > MAX_WORDS) begin err = 1; acc = 2; return; end
    x = b[0] ^ b[1];
    for (int k = 0; k < cnt; k++) begin
      p = 2 + 3 * k;
      if (p >= b.size()) return;
      if (b[p][7:2] != 6'd0) begin err = 1; acc = p + 1; return; end
      if (p + 2 >= b.size()) return;
      w.push_back({10'(k), b[p][1:0], b[p+1], b[p+2]});
      x = x ^ b[p] ^ b[p+1] ^ b[p+2];
    end
    p = 2 + 3 * cnt;
`ifdef LOADER_CHECKSUM_EN
    if (p >= b.size()) return;
    acc = p + 1;
    if (b[p] == x) ok = 1; else err = 1;
`else
    acc = p;
    ok = 1;
`endif
  endfunction

  function automatic bq_t build(input dq_t words);
    bq_t b;
    logic [9:0] c;
    logic [7:0] x;
    c = 10'(words.size());
    b.push_back({6'd0, c[9:8]});
    b.push_back(c[7:0]);
    foreach (words[k]) begin
      b.push_back({6'd0, words[k][17:16]});
      b.push_back(words[k][15:8]);
      b.push_back(words[k][7:0]);
    end
`ifdef LOADER_CHECKSUM_EN
    x = 8'd0;
    foreach (b[k]) x = x ^ b[k];
    b.push_back(x);
`else
    x = 8'd0;
`endif
    return b;
  endfunction

  // mode 0: back-to-back, 1: valid low on alternate cycles, 2: random bubbles.
  task automatic drive(input bq_t b, input int mode, output int acc);
    int i, guard;
    bit skip;
    i = 0; guard = 0;
    while (i < b.size() && guard < 20000) begin
      @(negedge clk);
      guard++;
      skip = (mode == 1) ? (guard % 2 == 0) : 1'b0;
      if (mode == 2) skip = ($urandom_range(0, 99) < 30);
      if (skip) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b[i];
        if (in_ready) i++;
        else break;
      end
    end
    acc = i;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wr_log.delete();
  endtask

  function automatic bq_t test1_stream();
    bq_t b;
    b = '{8'h00, 8'h02, 8'h03, 8'hC0, 8'h01, 8'h00, 8'h00, 8'h05};
`ifdef LOADER_CHECKSUM_EN
    b.push_back(8'hC5);
`endif
    return b;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (imem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", imem_we); else n_pass++;
    n_total++; if (imem_addr !== 10'd0) $display("FAIL rst_addr: got %h want 0", imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== 18'd0) $display("FAIL rst_wdata: got %h want 0", imem_wdata); else n_pass++;
    n_total++; if (cpu_hold !== 1'b1) $display("FAIL rst_hold: got %b want 1", cpu_hold); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else n_pass++;
  endtask

  task automatic test_basic();
    bq_t b;
    int acc;
    b = test1_stream();
    do_reset();
    drive(b, 0, acc);
`ifdef LOADER_CHECKSUM_EN
    n_total++; if (done !== 1'b1) $display("FAIL basic_done_timing: got %b want 1", done); else n_pass++;
    n_total++; if (cpu_hold !== 1'b0) $display("FAIL basic_hold_timing: got %b want 0", cpu_hold); else n_pass++;
`else
    n_total++; if (imem_we !== 1'b1 || done !== 1'b0) $display("FAIL basic_last_we: got we=%b done=%b want we=1 done=0", imem_we, done); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b1 || cpu_hold !== 1'b0) $display("FAIL basic_done_timing: got done=%b hold=%b want 1/0", done, cpu_hold); else n_pass++;
`endif
    repeat (2) @(negedge clk);
    n_total++; if (wr_log.size() != 2) $display("FAIL basic_nwrites: got %0d want 2", wr_log.size()); else n_pass++;
    if (wr_log.size() >= 2) begin
      n_total++; if (wr_log[0] !== {10'd0, 18'h3C001}) $display("FAIL basic_w0: got %h want %h", wr_log[0], {10'd0, 18'h3C001}); else n_pass++;
      n_total++; if (wr_log[1] !== {10'd1, 18'h00005}) $display("FAIL basic_w1: got %h want %h", wr_log[1], {10'd1, 18'h00005}); else n_pass++;
    end
    n_total++; if (error !== 1'b0 || in_ready !== 1'b0) $display("FAIL basic_final: got err=%b rdy=%b want 0/0", error, in_ready); else n_pass++;
    n_total++; if (acc != b.size()) $display("FAIL basic_accepted: got %0d want %0d", acc, b.size()); else n_pass++;
  endtask

  task automatic test_bad_checksum();
`ifdef LOADER_CHECKSUM_EN
    bq_t b;
    int acc;
    b = test1_stream();
    b[b.size()-1] = 8'hC4;
    do_reset();
    drive(b, 0, acc);
    n_total++; if (error !== 1'b1 || in_ready !== 1'b0) $display("FAIL badchk_err_timing: got err=%b rdy=%b want 1/0", error, in_ready); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if (wr_log.size() != 2) $display("FAIL badchk_nwrites: got %0d want 2", wr_log.size()); else n_pass++;
    n_total++; if (done !== 1'b0 || cpu_hold !== 1'b1) $display("FAIL badchk_final: got done=%b hold=%b want 0/1", done, cpu_hold); else n_pass++;
`endif
  endtask

  task automatic test_count_too_big();
    bq_t b;
    int acc;
    b = '{8'h03, 8'hFF, 8'h00, 8'h00, 8'h01};
    do_reset();
    drive(b, 0, acc);
    n_total++; if (acc != 2) $display("FAIL big_accepted: got %0d want 2", acc); else n_pass++;
    n_total++; if (error !== 1'b1 || in_ready !== 1'b0) $display("FAIL big_err: got err=%b rdy=%b want 1/0", error, in_ready); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (wr_log.size() != 0 || done !== 1'b0 || cpu_hold !== 1'b1) $display("FAIL big_final: got writes=%0d done=%b hold=%b want 0/0/1", wr_log.size(), done, cpu_hold); else n_pass++;
  endtask

  task automatic test_bad_b0();
    bq_t b;
    int acc;
    b = '{8'h00, 8'h01, 8'h04, 8'h00, 8'h00};
    do_reset();
    drive(b, 0, acc);
    n_total++; if (acc != 3) $display("FAIL badb0_accepted: got %0d want 3", acc); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (error !== 1'b1 || wr_log.size() != 0) $display("FAIL badb0_final: got err=%b writes=%0d want 1/0", error, wr_log.size()); else n_pass++;
  endtask

  task automatic test_gapped_and_reset();
    bq_t b, part;
    int acc;
    b = test1_stream();
    do_reset();
    drive(b, 1, acc);
    repeat (4) @(negedge clk);
    n_total++; if (wr_log.size() != 2 || wr_log[0] !== {10'd0, 18'h3C001} || wr_log[1] !== {10'd1, 18'h00005})
      $display("FAIL gap_writes: got n=%0d first=%h want n=2 first=%h", wr_log.size(), wr_log.size() > 0 ? wr_log[0] : 28'h0, {10'd0, 18'h3C001}); else n_pass++;
    n_total++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL gap_done: got done=%b err=%b want 1/0", done, error); else n_pass++;
    do_reset();
    for (int k = 0; k < 7; k++) part.push_back(b[k]);
    drive(part, 0, acc);
    n_total++; if (wr_log.size() != 1) $display("FAIL mid_partial_writes: got %0d want 1", wr_log.size()); else n_pass++;
    do_reset();
    n_total++; if (in_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_wdata !== 18'd0)
      $display("FAIL mid_rst_outs: got rdy=%b we=%b addr=%h data=%h want 1/0/0/0", in_ready, imem_we, imem_addr, imem_wdata); else n_pass++;
    n_total++; if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL mid_rst_flags: got hold=%b done=%b err=%b want 1/0/0", cpu_hold, done, error); else n_pass++;
    drive(b, 0, acc);
    repeat (4) @(negedge clk);
    n_total++; if (wr_log.size() < 1 || wr_log[0] !== {10'd0, 18'h3C001}) $display("FAIL mid_reload_first: got n=%0d want addr0 first", wr_log.size()); else n_pass++;
    n_total++; if (done !== 1'b1 || cpu_hold !== 1'b0) $display("FAIL mid_reload_done: got done=%b hold=%b want 1/0", done, cpu_hold); else n_pass++;
  endtask

  task automatic test_max_count();
    dq_t words;
    bq_t b;
    wq_t ew;
    bit eok, eerr;
    int acc, eacc, bad;
    for (int k = 0; k < 1022; k++) words.push_back(18'(k));
    b = build(words);
    model(b, ew, eok, eerr, eacc);
    do_reset();
    drive(b, 0, acc);
    repeat (4) @(negedge clk);
    n_total++; if (wr_log.size() != 1022) $display("FAIL max_nwrites: got %0d want 1022", wr_log.size()); else n_pass++;
    n_total++; if (wr_log.size() < 1 || wr_log[wr_log.size()-1] !== {10'd1021, 18'h003FD}) $display("FAIL max_last: got n=%0d want last %h", wr_log.size(), {10'd1021, 18'h003FD}); else n_pass++;
    bad = 0;
    foreach (ew[k]) if (k >= wr_log.size() || wr_log[k] !== ew[k]) bad++;
    n_total++; if (bad != 0) $display("FAIL max_all_writes: got %0d bad want 0", bad); else n_pass++;
    n_total++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) $display("FAIL max_final: got done=%b hold=%b err=%b want 1/0/0", done, cpu_hold, error); else n_pass++;
  endtask

  task automatic test_random();
    dq_t words;
    bq_t b;
    wq_t ew;
    bit eok, eerr;
    int acc, eacc, kind, r, bad;
    for (int it = 0; it < 24; it++) begin
      words = {};
      for (int k = 0; k < $urandom_range(1, 6); k++) words.push_back(18'($urandom()));
      b = build(words);
      kind = $urandom_range(0, 5);
      r = $urandom_range(0, 5);
      case (kind)
        1: b[0] = b[0] | (8'h04 << r);
        2: begin b[0] = 8'h03; b[1] = 8'hFF; end
        3: begin b[0] = 8'h00; b[1] = 8'h00; end
        4: begin int j; j = $urandom_range(0, words.size() - 1); b[2+3*j] = b[2+3*j] | (8'h04 << r); end
        5: b[b.size()-1] = b[b.size()-1] ^ (8'h01 << r);
        default: ;
      endcase
      model(b, ew, eok, eerr, eacc);
      do_reset();
      drive(b, 2, acc);
      repeat (4) @(negedge clk);
      bad = 0;
      foreach (ew[k]) if (k >= wr_log.size() || wr_log[k] !== ew[k]) bad++;
      n_total++; if (acc != eacc) $display("FAIL rnd%0d_accepted: got %0d want %0d", it, acc, eacc); else n_pass++;
      n_total++; if (wr_log.size() != ew.size() || bad != 0) $display("FAIL rnd%0d_writes: got n=%0d bad=%0d want n=%0d", it, wr_log.size(), bad, ew.size()); else n_pass++;
      n_total++; if (done !== eok || error !== eerr || cpu_hold !== !eok || in_ready !== 1'b0)
        $display("FAIL rnd%0d_status: got done=%b err=%b hold=%b rdy=%b want %b/%b/%b/0", it, done, error, cpu_hold, in_ready, eok, eerr, !eok); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_count_too_big();
    test_bad_b0();
    test_gapped_and_reset();
    test_max_count();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
